// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR coefficient controller and the FIR wrapper:
// coefficient width, controller state encoding and tap packing position.
package fir_ctrl_pkg;

    localparam int unsigned COEFF_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWAP,
        ST_BLANK
    } fir_ctrl_state_e;

    // LSB position of tap idx in a packed bank; tap 0 sits at the MSBs.
    function automatic int unsigned coeff_lsb(input int unsigned taps, input int unsigned idx);
        return COEFF_W * (taps - 1 - idx);
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow coefficient register file: one synchronous write port, one async
// read-back port, and the whole bank presented packed for an atomic copy.
module fir_coeff_bank
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned TAPS = 9,
    parameter int unsigned AW   = $clog2(TAPS)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      wr_en_i,
    input  logic [AW-1:0]             wr_addr_i,
    input  logic [COEFF_W-1:0]        wr_data_i,
    input  logic [AW-1:0]             rd_addr_i,
    output logic [COEFF_W-1:0]        rd_data_o,
    output logic [COEFF_W*TAPS-1:0]   bank_o
);

    localparam logic [AW:0] TAPS_LIM = TAPS[AW:0];

    logic [COEFF_W-1:0] mem [TAPS];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = '0;
        if ({1'b0, rd_addr_i} < TAPS_LIM) begin
            rd_data_o = mem[rd_addr_i];
        end
    end

    always_comb begin
        bank_o = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            bank_o[coeff_lsb(TAPS, i) +: COEFF_W] = mem[i];
        end
    end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Coefficient bank controller: shadow writes, atomic commit into the active
// bank, then output-valid blanking for FIR_LAT cycles while old taps drain.
module fir_coeff_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int unsigned TAPS    = 9,
    parameter int unsigned FIR_LAT = 5,
    parameter int unsigned AW      = $clog2(TAPS)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      wr_en_i,
    input  logic [AW-1:0]             wr_addr_i,
    input  logic [COEFF_W-1:0]        wr_data_i,
    input  logic [AW-1:0]             rd_addr_i,
    output logic [COEFF_W-1:0]        rd_data_o,
    input  logic                      commit_i,
    output logic                      busy_o,
    output logic                      err_o,
    output logic [COEFF_W*TAPS-1:0]   coeff_o,
    input  logic                      fir_valid_i,
    output logic                      valid_o,
    output logic                      swap_done_o
);

    localparam int unsigned CW       = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FIR_LAT - 1);
    localparam logic [AW:0]   TAPS_LIM = TAPS[AW:0];

    fir_ctrl_state_e             state_q, state_d;
    logic [CW-1:0]               cnt_q;
    logic [COEFF_W*TAPS-1:0]     active_q;
    logic [COEFF_W*TAPS-1:0]     shadow_bank;
    logic                        err_q;
    logic                        idle;
    logic                        addr_ok;
    logic                        shadow_we;
    logic                        reject;

    assign idle      = (state_q == ST_IDLE);
    assign addr_ok   = ({1'b0, wr_addr_i} < TAPS_LIM);
    assign shadow_we = idle & wr_en_i & addr_ok;
    assign reject    = idle ? (wr_en_i & ~addr_ok) : (wr_en_i | commit_i);

    fir_coeff_bank #(
        .TAPS (TAPS),
        .AW   (AW)
    ) u_shadow (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .wr_en_i   (shadow_we),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o),
        .bank_o    (shadow_bank)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= reject;
            if (state_q == ST_SWAP) begin
                active_q <= shadow_bank;
                cnt_q    <= CNT_INIT;
            end else if (state_q == ST_BLANK && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        swap_done_o = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (commit_i) state_d = ST_SWAP;
            ST_SWAP:  state_d = ST_BLANK;
            ST_BLANK: begin
                if (cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    swap_done_o = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy_o  = ~idle;
    assign err_o   = err_q;
    assign coeff_o = active_q;
    assign valid_o = fir_valid_i & idle;

endmodule

// File: doc/fir_coeff_ctrl.md
# fir_coeff_ctrl

Coefficient bank controller for the parallel FIR filter. Software-side writes land in a shadow bank. A commit request copies the shadow bank atomically into the active bank that drives the filter's packed coefficient input. The block then blanks the filter's output-valid for a programmable number of cycles, so downstream never consumes samples computed with a mix of old and new taps. It sits between the register interface and the FIR, one instance per filter.

## Interface
Parameters:
- TAPS, 9, number of filter taps (≥2)
- FIR_LAT, 5, filter latency in clocks (multiplier plus adder-tree stages); this is the blanking length
- AW, $clog2(TAPS), tap address width

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  system clock, all logic on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- wr_en_i  in  1  shadow write strobe, one write per cycle
- wr_addr_i  in  AW  tap index 0..TAPS-1
- wr_data_i  in  18  signed coefficient, two's complement, CoeffFracBits as configured in the filter
- rd_addr_i  in  AW  shadow read-back index
- rd_data_o  out  18  shadow[rd_addr_i], combinational; 0 if index out of range
- commit_i  in  1  request to copy shadow into active
- busy_o  out  1  high while not IDLE
- err_o  out  1  one-cycle pulse on a rejected write or commit
- coeff_o  out  18*TAPS  active bank; tap i at [18*(TAPS-i)-1 -: 18], so tap 0 is at the MSBs
- fir_valid_i  in  1  valid_o from the FIR
- valid_o  out  1  fir_valid_i gated by the blanking window
- swap_done_o  out  1  one-cycle pulse when blanking ends

## Operation
- States: IDLE, SWAP, BLANK.
- IDLE:
  - wr_en_i with wr_addr_i < TAPS writes shadow[wr_addr_i] at the clock edge.
  - wr_addr_i ≥ TAPS: no write, err_o pulses.
  - commit_i moves the FSM to SWAP. If wr_en_i and commit_i are high in the same cycle, the write takes effect and is included in the copy.
- SWAP (1 cycle): active <= shadow (all taps at once); blank counter <= FIR_LAT-1; go to BLANK.
- BLANK:
  - Counter decrements each cycle. When it reaches 0, go to IDLE and pulse swap_done_o in that same cycle.
  - The counter advances on every clock, independent of fir_valid_i, because the adder tree advances every clock.
- In SWAP or BLANK: wr_en_i and commit_i are ignored, err_o pulses for each, and the shadow is unchanged.
- valid_o = fir_valid_i & ~blank, where blank is high in SWAP and BLANK. valid_o is combinational from registered state.
- The shadow is never modified by a commit, so repeated commits re-apply the same taps.

## Timing
- Reset values:
  - shadow and active all zero; coeff_o = 0
  - FSM IDLE; busy_o=0, err_o=0, swap_done_o=0
  - valid_o follows fir_valid_i & 1 (not blanked)
- A write at edge N is visible on rd_data_o after edge N.
- Commit sampled at edge N:
  - SWAP during cycle N+1; coeff_o changes at edge N+2.
  - BLANK occupies cycles N+2..N+1+FIR_LAT.
  - valid_o is low in cycles N+1..N+1+FIR_LAT inclusive.
  - swap_done_o is high in cycle N+1+FIR_LAT.
  - busy_o is back low from cycle N+2+FIR_LAT.
- FIR_LAT=1: BLANK lasts one cycle.
- Reset asserted mid-operation immediately returns the block to the reset state: active bank zeroed, blanking cancelled, no swap_done_o pulse.

## Structure
- A shared package fir_ctrl_pkg holds: COEFF_W=18, the state enum typedef, and the coefficient-packing index function (shared with the FIR wrapper).
- The 18×TAPS shadow register file is a natural sub-module, fir_coeff_bank (write port plus async read port). It is instantiated once; the active bank is a plain register.
- Target 150–250 lines total.

## Test plan
- Reset with fir_valid_i=1 -> coeff_o=0, busy_o=0, valid_o=1, rd_data_o=0 for every address.
- Write taps 0..8 = 1..9, read back -> rd_data_o = 1..9. Commit -> coeff_o[161:144]=1 and [17:0]=9 from edge N+2. valid_o low exactly FIR_LAT+1 cycles (6 at default). swap_done_o pulses once.
- Write addr 9 (TAPS=9) -> err_o one pulse, no shadow change. Write plus commit in the same cycle -> the written tap appears in coeff_o.
- Write and commit during BLANK -> err_o pulse each, shadow and active unchanged, FSM returns to IDLE on schedule.
- Assert rst_n_i in the third BLANK cycle -> coeff_o=0 and busy_o=0 immediately, valid_o ungated, no swap_done_o.
- Back-to-back commits (commit held high through busy) -> second request rejected with err_o. A commit re-issued after swap_done_o starts a new swap with an identical blank length.
